muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Sequential 32-bit multiply/divide unit with architectural HI/LO registers for the mips789 core. It executes MULT/MULTU/DIV/DIVU as a radix-2 iteration of exactly 32 cycles and serves MFHI/MFLO/MTHI/MTLO. It sits in the execute stage beside the ALU. Its latency is sized to complete inside the pipeline controller's MUL stall window, which is 33 cycles from entry to exit.

## Interface
Parameters:
- WIDTH, 32, operand/HI/LO width (only 32 is supported by the core).
- CNT_W, 6, iteration counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- op  input  4  operation code: MD_NOP, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MFHI, MD_MFLO, MD_MTHI, MD_MTLO.
- a  input  WIDTH  rs operand (dividend / multiplicand / MTxx source).
- b  input  WIDTH  rt operand (divisor / multiplier).
- res  output  WIDTH  MFHI/MFLO read data (combinational from HI/LO).
- busy  output  1  iteration in progress.
- done  output  1  one-cycle pulse when HI/LO have been updated by an arithmetic op.

## Operation
- States: IDLE, RUN, FIX.
  - IDLE -> RUN on an arithmetic op; operands are latched on that edge.
  - RUN lasts 32 cycles (counter 0..31).
  - RUN -> FIX at count 31.
  - FIX -> IDLE after one cycle. In FIX, sign correction is applied and HI/LO are written.
- Operand handling:
  - Signed ops (MULT, DIV) work on absolute values and record sign_q = a[31]^b[31] and sign_r = a[31].
  - Unsigned ops record both signs as 0.
- Multiply:
  - Shift-add, 64-bit accumulator {hi_t, lo_t}, one multiplier bit per cycle, LSB first.
  - In FIX, the 64-bit product is negated if sign_q = 1.
  - HI = product[63:32], LO = product[31:0].
- Divide:
  - Restoring, one quotient bit per cycle, MSB first, 33-bit partial remainder.
  - In FIX, LO = quotient (negated if sign_q) and HI = remainder (negated if sign_r).
- Divide by zero: LO = 0xFFFFFFFF and HI = a, unsigned magnitude restored with its original sign. The result is written in FIX after the full 32 cycles (no early exit).
- Overflow case 0x80000000 / 0xFFFFFFFF signed: LO = 0x80000000, HI = 0. This falls out naturally from the 33-bit path and must not trap.
- MTHI/MTLO write `a` into HI/LO on the issuing edge when not busy.
- MFHI/MFLO drive res = HI/LO combinationally. Any other op drives res = 0.
- Busy rules:
  - Any op other than MD_NOP/MFxx arriving while busy is ignored: no latch, no HI/LO write.
  - MFxx while busy returns the stale HI/LO.
- Reset values: HI = 0, LO = 0, state IDLE, counter 0, busy = 0, done = 0, res = 0.
- Reset asserted mid-operation aborts immediately. HI/LO clear to 0 and no done pulse is issued.

## Timing
- An arithmetic op is sampled at edge N.
- busy = 1 for cycles N+1..N+33 (RUN 32 cycles + FIX 1 cycle).
- done = 1 during cycle N+34, together with busy = 0. HI/LO are visible via MFxx from cycle N+34.
- An arithmetic op issued at edge N+34 is accepted: back-to-back issue is allowed, with no idle bubble required.
- MTxx issued at edge N is visible through MFxx at cycle N+1.
- busy is a registered output. done is registered and asserted for exactly one cycle.

## Structure
- MD_* op encodings (4-bit) belong in the shared mips789_defs include, next to the FSM_*/PC_* constants.
- State encodings stay local.
- One sub-module, muldiv_step: the combinational single iteration for both mul (add/shift) and div (subtract/compare/shift), selected by a mode bit.

## Test plan
- **Signed multiply:** MULT a=0xFFFFFFFF, b=0x00000002.
  - busy for 33 cycles, done at N+34.
  - MFHI = 0xFFFFFFFF, MFLO = 0xFFFFFFFE.
- **Unsigned multiply:** MULTU a=0xFFFFFFFF, b=0x00000002 -> HI = 0x00000001, LO = 0xFFFFFFFE.
- **Signed divide:** DIV a=0xFFFFFFF9 (-7), b=2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- **Divide by zero:** DIVU a=7, b=0 -> LO = 0xFFFFFFFF, HI = 0x00000007, latency unchanged (done at N+34).
- **Busy rules:**
  - MTHI 0x1234 then MFHI next cycle -> 0x1234.
  - MULT issued, then MTLO 0x55 and DIV issued at N+5 -> both ignored; the MULT result is intact.
  - Back-to-back MULT at N+34 accepted.
- **Reset mid-op:** rst low at N+10 during MULT -> busy = 0, HI = LO = 0 immediately; no done pulse after release.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the mips789 multiply/divide unit: MD_* op codes and
// small op-classification helpers.
package muldiv_seq_pkg;

  localparam logic [3:0] MD_NOP   = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  function automatic logic is_arith(input logic [3:0] op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: is_arith = 1'b1;
      default:                            is_arith = 1'b0;
    endcase
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    case (op)
      MD_DIV, MD_DIVU: is_div = 1'b1;
      default:         is_div = 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    case (op)
      MD_MULT, MD_DIV: is_signed_op = 1'b1;
      default:         is_signed_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_seq_step.sv
// One radix-2 iteration: shift-add multiply (LSB first) or restoring divide
// (MSB first) on the {hi, lo} accumulator, chosen by mode_div.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             mode_div,
  input  logic [WIDTH:0]   hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH+1:0] sum;
  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] diff;

  // Next accumulator value for either mode
  always_comb begin
    sum    = {1'b0, hi} + {2'b00, (lo[0] ? m : {WIDTH{1'b0}})};
    rem_sh = {hi, lo[WIDTH-1]};
    diff   = rem_sh - {2'b00, m};
    if (mode_div) begin
      // Non-negative difference means the divisor fits: keep it, quotient bit 1
      if (!diff[WIDTH+1]) begin
        hi_next = diff[WIDTH:0];
        lo_next = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = rem_sh[WIDTH:0];
        lo_next = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_next = sum[WIDTH+1:1];
      lo_next = {sum[0], lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential 32-bit MULT/MULTU/DIV/DIVU unit with architectural HI/LO;
// 32 RUN cycles plus one FIX cycle for sign correction and HI/LO write-back.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   mcand;
  logic               mode_div;
  logic               sign_q;
  logic               sign_r;
  logic               div_zero;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  logic               op_signed;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode_div (mode_div),
    .hi       (acc_hi),
    .lo       (acc_lo),
    .m        (mcand),
    .hi_next  (step_hi),
    .lo_next  (step_lo)
  );

  // Operand magnitudes for signed ops
  always_comb begin
    op_signed = is_signed_op(op);
    if (op_signed && a[WIDTH-1]) begin
      abs_a = -a;
    end else begin
      abs_a = a;
    end
    if (op_signed && b[WIDTH-1]) begin
      abs_b = -b;
    end else begin
      abs_b = b;
    end
  end

  // Sign-corrected results written to HI/LO in FIX
  always_comb begin
    prod = {acc_hi[WIDTH-1:0], acc_lo};
    if (sign_q) begin
      prod_fix = -prod;
    end else begin
      prod_fix = prod;
    end
    if (mode_div) begin
      // Divide by zero reports all-ones quotient regardless of operand signs
      if (div_zero) begin
        fix_lo = {WIDTH{1'b1}};
      end else if (sign_q) begin
        fix_lo = -acc_lo;
      end else begin
        fix_lo = acc_lo;
      end
      if (sign_r) begin
        fix_hi = -acc_hi[WIDTH-1:0];
      end else begin
        fix_hi = acc_hi[WIDTH-1:0];
      end
    end else begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
  end

  // MFHI/MFLO read port
  always_comb begin
    case (op)
      MD_MFHI: res = hi;
      MD_MFLO: res = lo;
      default: res = {WIDTH{1'b0}};
    endcase
  end

  // Control FSM, iteration datapath and HI/LO registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= {CNT_W{1'b0}};
      acc_hi   <= {(WIDTH+1){1'b0}};
      acc_lo   <= {WIDTH{1'b0}};
      mcand    <= {WIDTH{1'b0}};
      mode_div <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
      hi       <= {WIDTH{1'b0}};
      lo       <= {WIDTH{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (is_arith(op)) begin
            mode_div <= is_div(op);
            sign_q   <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            sign_r   <= op_signed & a[WIDTH-1];
            div_zero <= is_div(op) & (b == {WIDTH{1'b0}});
            acc_hi   <= {(WIDTH+1){1'b0}};
            acc_lo   <= is_div(op) ? abs_a : abs_b;
            mcand    <= is_div(op) ? abs_b : abs_a;
            cnt      <= {CNT_W{1'b0}};
            busy     <= 1'b1;
            state    <= ST_RUN;
          end else if (op == MD_MTHI) begin
            hi <= a;
          end else if (op == MD_MTLO) begin
            lo <= a;
          end
        end
        ST_RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            cnt   <= {CNT_W{1'b0}};
            state <= ST_FIX;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, random ops against
// an arithmetic reference model, and hand-written busy/reset sequences.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] res;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  muldiv_seq dut (
    .clk  (clk),
    .rst  (rst),
    .op   (op),
    .a    (a),
    .b    (b),
    .res  (res),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference results straight from MIPS arithmetic semantics
  task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] mh, output logic [31:0] ml);
    logic signed [63:0] sp;
    logic [63:0]        up;
    int                 sx;
    int                 sy;
    mh = 32'h0;
    ml = 32'h0;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      MD_MULT: begin
        sp = $signed(x) * $signed(y);
        mh = sp[63:32];
        ml = sp[31:0];
      end
      MD_MULTU: begin
        up = {32'h0, x} * {32'h0, y};
        mh = up[63:32];
        ml = up[31:0];
      end
      MD_DIV, MD_DIVU: begin
        if (y == 32'h0) begin
          ml = 32'hFFFF_FFFF;
          mh = x;
        end else if (o == MD_DIV && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          ml = 32'h8000_0000;
          mh = 32'h0;
        end else if (o == MD_DIV) begin
          ml = sx / sy;
          mh = sx % sy;
        end else begin
          ml = x / y;
          mh = x % y;
        end
      end
      default: begin
        mh = 32'h0;
        ml = 32'h0;
      end
    endcase
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
    op = MD_MFHI;
    #1;
    check({tag, "_hi"}, res, eh);
    op = MD_MFLO;
    #1;
    check({tag, "_lo"}, res, el);
    op = MD_NOP;
  endtask

  // Present an op so it is sampled at the next rising edge; returns 1ns after it
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o;
    a  = x;
    b  = y;
    @(posedge clk);
    #1;
    op = MD_NOP;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (busy === 1'b1 && k < 60) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic run_arith(input string tag, input logic [3:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    int k;
    issue(o, x, y);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(k);
    check({tag, "_latency"}, 32'(k), 32'd33);
    check({tag, "_done"}, 32'(done), 32'd1);
    read_hilo(tag, eh, el);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [31:0] eh;
    logic [31:0] el;
    logic [3:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          k;
    int          done_seen;

    vecs[0] = '{MD_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1] = '{MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[4] = '{MD_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[5] = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[6] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[7] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8] = '{MD_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[9] = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};

    rst = 1'b0;
    op  = MD_NOP;
    a   = 32'h0;
    b   = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    read_hilo("reset", 32'h0, 32'h0);
    op = MD_MULT;
    #1;
    check("reset_res_nonmf", res, 32'h0);
    op = MD_NOP;
    @(negedge clk);
    rst = 1'b1;

    // MTHI/MTLO visible on the following cycle
    issue(MD_MTHI, 32'h0000_1234, 32'h0);
    op = MD_MFHI;
    #1;
    check("mthi_mfhi", res, 32'h0000_1234);
    issue(MD_MTLO, 32'hCAFE_0055, 32'h0);
    op = MD_MFLO;
    #1;
    check("mtlo_mflo", res, 32'hCAFE_0055);
    op = MD_NOP;

    for (int i = 0; i < 10; i++) begin
      run_arith($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
    end

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(3))
        0:       ro = MD_MULT;
        1:       ro = MD_MULTU;
        2:       ro = MD_DIV;
        default: ro = MD_DIVU;
      endcase
      ra = $urandom;
      case ($urandom_range(7))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      model(ro, ra, rb, eh, el);
      run_arith($sformatf("rnd%0d", i), ro, ra, rb, eh, el);
    end

    // Ops arriving while busy are ignored; MFxx returns stale values
    run_arith("pre_busy", MD_MULTU, 32'd3, 32'd5, 32'h0, 32'd15);
    issue(MD_MULT, 32'hFFFF_0000, 32'h0001_2345);
    repeat (3) @(posedge clk);
    @(negedge clk);
    op = MD_MTLO;
    a  = 32'h0000_0055;
    @(negedge clk);
    op = MD_DIV;
    a  = 32'd100;
    b  = 32'd7;
    @(posedge clk);
    #1;
    op = MD_MFLO;
    #1;
    check("busy_stale_lo", res, 32'd15);
    op = MD_NOP;
    wait_done(k);
    check("busy_latency", 32'(k + 5), 32'd33);
    model(MD_MULT, 32'hFFFF_0000, 32'h0001_2345, eh, el);
    read_hilo("busy_ignore", eh, el);

    // Back-to-back issue in the cycle done is high
    issue(MD_MULT, 32'h0000_0003, 32'hFFFF_FFFB);
    wait_done(k);
    check("b2b_first_latency", 32'(k), 32'd33);
    op = MD_MULT;
    a  = 32'h1234_5678;
    b  = 32'h0000_1000;
    @(posedge clk);
    #1;
    op = MD_NOP;
    check("b2b_accept", 32'(busy), 32'd1);
    wait_done(k);
    check("b2b_latency", 32'(k), 32'd33);
    read_hilo("b2b", 32'h0000_0123, 32'h4567_8000);

    // Reset in the middle of an operation
    issue(MD_MULT, 32'd5, 32'd6);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    read_hilo("rstmid", 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
    end
    check("rstmid_no_done", 32'(done_seen), 32'd0);
    check("rstmid_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
